// File: rtl/uart_frame_pkg.sv
// Shared types and helpers for the framed UART receiver: frame FSM states,
// baud divisor calculation and the bytewise CRC-8 step.
package uart_frame_pkg;

  typedef enum logic [1:0] {S_HUNT, S_PAYLOAD, S_CRC, S_TAIL} frame_state_e;

  function automatic int unsigned calc_bps_cnt(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

  // MSB-first, non-reflected CRC-8 over one byte.
  function automatic logic [7:0] crc8_next(input logic [7:0] crc,
                                           input logic [7:0] data,
                                           input logic [7:0] poly);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ poly) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/uart_rx_byte_core.sv
// Single-byte UART receiver: 2-flop synchroniser, start-bit glitch filter,
// mid-bit sampling of 8 data bits (LSB first) and stop-bit check.
module uart_rx_byte_core #(
  parameter int unsigned BPS_CNT = 434
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rxd_i,
  output logic [7:0] byte_data_o,
  output logic       byte_valid_o,
  output logic       stop_err_o
);

  localparam int unsigned CntW = (BPS_CNT > 2) ? $clog2(BPS_CNT) : 1;
  localparam logic [CntW-1:0] HalfCnt = CntW'(BPS_CNT / 2);
  localparam logic [CntW-1:0] FullCnt = CntW'(BPS_CNT - 1);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  rx_state_e       state_q;
  logic [1:0]      sync_q;
  logic            rxd_prev_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic [7:0]      data_q;
  logic            valid_q;
  logic            stop_err_q;
  logic            rxd_s;

  assign rxd_s = sync_q[1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q     <= 2'b11;
      rxd_prev_q <= 1'b1;
      state_q    <= RxIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      stop_err_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], rxd_i};
      rxd_prev_q <= rxd_s;
      valid_q    <= 1'b0;
      stop_err_q <= 1'b0;
      unique case (state_q)
        RxIdle: begin
          if (rxd_prev_q && !rxd_s) begin
            state_q <= RxStart;
            cnt_q   <= '0;
          end
        end
        RxStart: begin
          // Start bit must still be low at mid-bit, otherwise it was a glitch.
          if (cnt_q == HalfCnt) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= rxd_s ? RxIdle : RxData;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RxData: begin
          if (cnt_q == FullCnt) begin
            cnt_q   <= '0;
            shift_q <= {rxd_s, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= RxStop;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RxStop: begin
          if (cnt_q == FullCnt) begin
            cnt_q   <= '0;
            state_q <= RxIdle;
            if (rxd_s) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
            end else begin
              stop_err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= RxIdle;
      endcase
    end
  end

  assign byte_data_o  = data_q;
  assign byte_valid_o = valid_q;
  assign stop_err_o   = stop_err_q;

endmodule

// File: rtl/uart_frame_rx_crc.sv
// Framed UART receiver: HEAD, payload, optional CRC-8, TAIL. Good payloads are
// presented on a flat bus under a valid/ready handshake with inline error pulses.
module uart_frame_rx_crc import uart_frame_pkg::*; #(
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned UART_BPS     = 115_200,
  parameter int unsigned PAYLOAD_LEN  = 11,
  parameter logic [7:0]  HEAD_BYTE    = 8'h55,
  parameter logic [7:0]  TAIL_BYTE    = 8'hAA,
  parameter bit          CRC_EN       = 1'b1,
  parameter logic [7:0]  CRC_POLY     = 8'h07,
  parameter logic [7:0]  CRC_INIT     = 8'h00,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     uart_rxd,
  output logic [7:0]               byte_data,
  output logic                     byte_valid,
  output logic [8*PAYLOAD_LEN-1:0] frame_data,
  output logic                     frame_valid,
  input  logic                     frame_ready,
  output logic                     busy,
  output logic                     err_crc,
  output logic                     err_frame,
  output logic                     err_timeout,
  output logic                     err_overrun
);

  localparam int unsigned BPS_CNT = calc_bps_cnt(CLK_FREQ, UART_BPS);
  localparam int unsigned ToLimit = TIMEOUT_BITS * BPS_CNT;
  localparam int unsigned ToW     = $clog2(ToLimit + 1);
  localparam int unsigned IdxW    = $clog2(PAYLOAD_LEN + 1);
  localparam logic [ToW-1:0]  ToLimitV = ToW'(ToLimit);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(PAYLOAD_LEN - 1);

  frame_state_e             state_q;
  logic [IdxW-1:0]          idx_q;
  logic [7:0]               crc_q;
  logic [8*PAYLOAD_LEN-1:0] shadow_q;
  logic [8*PAYLOAD_LEN-1:0] frame_data_q;
  logic                     frame_valid_q;
  logic                     err_crc_q, err_frame_q, err_timeout_q, err_overrun_q;
  logic [ToW-1:0]           to_cnt_q;
  logic [7:0]               rx_data;
  logic                     rx_valid;
  logic                     rx_stop_err;

  uart_rx_byte_core #(
    .BPS_CNT(BPS_CNT)
  ) u_rx_byte_core (
    .clk_i       (sys_clk),
    .rst_i       (sys_rst_n),
    .rxd_i       (uart_rxd),
    .byte_data_o (rx_data),
    .byte_valid_o(rx_valid),
    .stop_err_o  (rx_stop_err)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst_n) begin
      state_q       <= S_HUNT;
      idx_q         <= '0;
      crc_q         <= CRC_INIT;
      shadow_q      <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      err_crc_q     <= 1'b0;
      err_frame_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
      to_cnt_q      <= '0;
    end else begin
      err_crc_q     <= 1'b0;
      err_frame_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
      if (frame_valid_q && frame_ready) frame_valid_q <= 1'b0;

      if (rx_stop_err) begin
        state_q     <= S_HUNT;
        err_frame_q <= 1'b1;
        to_cnt_q    <= '0;
      end else if (rx_valid) begin
        to_cnt_q <= '0;
        unique case (state_q)
          S_HUNT: begin
            if (rx_data == HEAD_BYTE) begin
              state_q <= S_PAYLOAD;
              idx_q   <= '0;
              crc_q   <= CRC_INIT;
            end
          end
          S_PAYLOAD: begin
            shadow_q[8*idx_q +: 8] <= rx_data;
            crc_q <= crc8_next(crc_q, rx_data, CRC_POLY);
            idx_q <= idx_q + 1'b1;
            if (idx_q == LastIdx) state_q <= CRC_EN ? S_CRC : S_TAIL;
          end
          S_CRC: begin
            if (rx_data != crc_q) begin
              err_crc_q <= 1'b1;
              state_q   <= S_HUNT;
            end else begin
              state_q <= S_TAIL;
            end
          end
          S_TAIL: begin
            state_q <= S_HUNT;
            // A frame accepted this cycle frees the output, so the new one may load.
            if (rx_data != TAIL_BYTE) begin
              err_frame_q <= 1'b1;
            end else if (frame_valid_q && !frame_ready) begin
              err_overrun_q <= 1'b1;
            end else begin
              frame_data_q  <= shadow_q;
              frame_valid_q <= 1'b1;
            end
          end
          default: state_q <= S_HUNT;
        endcase
      end else if (state_q != S_HUNT) begin
        if (to_cnt_q == ToLimitV) begin
          err_timeout_q <= 1'b1;
          state_q       <= S_HUNT;
          to_cnt_q      <= '0;
        end else begin
          to_cnt_q <= to_cnt_q + 1'b1;
        end
      end else begin
        to_cnt_q <= '0;
      end
    end
  end

  assign byte_data   = rx_data;
  assign byte_valid  = rx_valid;
  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign busy        = (state_q != S_HUNT);
  assign err_crc     = err_crc_q;
  assign err_frame   = err_frame_q;
  assign err_timeout = err_timeout_q;
  assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_uart_frame_rx_crc.sv
// Directed bench for uart_frame_rx_crc: 9-byte payload, 16 clocks per bit.
module tb_uart_frame_rx_crc;

  localparam int unsigned Bps    = 16;
  localparam int unsigned PayLen = 9;
  localparam int unsigned ToBits = 20;
  localparam logic [71:0] P1     = 72'h39_38_37_36_35_34_33_32_31;
  localparam logic [71:0] P0     = 72'h0;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        rxd   = 1'b1;
  logic        ready = 1'b0;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic [71:0] frame_data;
  logic        frame_valid, busy, err_crc, err_frame, err_timeout, err_overrun;

  always #5 clk = ~clk;

  uart_frame_rx_crc #(
    .CLK_FREQ    (1_000_000),
    .UART_BPS    (62_500),
    .PAYLOAD_LEN (PayLen),
    .TIMEOUT_BITS(ToBits)
  ) dut (
    .sys_clk    (clk),
    .sys_rst_n  (rst),
    .uart_rxd   (rxd),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .frame_data (frame_data),
    .frame_valid(frame_valid),
    .frame_ready(ready),
    .busy       (busy),
    .err_crc    (err_crc),
    .err_frame  (err_frame),
    .err_timeout(err_timeout),
    .err_overrun(err_overrun)
  );

  // Event counters, sampled on every clock.
  int   cyc = 0, n_byte = 0, n_rise = 0, n_crc = 0, n_ferr = 0, n_to = 0, n_ovr = 0;
  int   last_bv = 0, to_at = 0;
  logic fv_prev = 1'b0;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    fv_prev <= frame_valid;
    if (byte_valid) begin
      n_byte  <= n_byte + 1;
      last_bv <= cyc;
    end
    if (frame_valid && !fv_prev) n_rise <= n_rise + 1;
    if (err_crc) n_crc <= n_crc + 1;
    if (err_frame) n_ferr <= n_ferr + 1;
    if (err_overrun) n_ovr <= n_ovr + 1;
    if (err_timeout) begin
      n_to  <= n_to + 1;
      to_at <= cyc;
    end
  end

  int n_vec = 0, n_bad = 0;
  int b_byte, b_rise, b_crc, b_ferr, b_to, b_ovr;

  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    b_byte = n_byte; b_rise = n_rise; b_crc = n_crc;
    b_ferr = n_ferr; b_to = n_to; b_ovr = n_ovr;
  endtask

  task automatic bit_time(input logic v);
    rxd = v;
    repeat (Bps) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop);
    rxd = 1'b1;
  endtask

  task automatic send_frame(input logic [71:0] pl, input logic [7:0] crc, input logic [7:0] tail);
    send_byte(8'h55, 1'b1);
    for (int i = 0; i < PayLen; i++) send_byte(pl[8*i +: 8], 1'b1);
    send_byte(crc, 1'b1);
    send_byte(tail, 1'b1);
    repeat (4) @(negedge clk);
  endtask

  task automatic accept(input string tag);
    check_eq({tag, "_held"}, frame_valid, 1'b1);
    ready = 1'b1;
    @(negedge clk);
    check_eq({tag, "_drop"}, frame_valid, 1'b0);
    ready = 1'b0;
  endtask

  initial begin
    int diff;
    repeat (5) @(negedge clk);
    check_eq("rst_fvalid", frame_valid, 1'b0);
    check_eq("rst_fdata", frame_data, P0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_errs", {err_crc, err_frame, err_timeout, err_overrun, byte_valid}, 5'b0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Good frame, CRC-8 of "123456789" is F4.
    snap();
    send_frame(P1, 8'hF4, 8'hAA);
    check_eq("good_rise", n_rise - b_rise, 1);
    check_eq("good_lo", frame_data[7:0], 8'h31);
    check_eq("good_hi", frame_data[71:64], 8'h39);
    check_eq("good_data", frame_data, P1);
    check_eq("good_bytes", n_byte - b_byte, 12);
    check_eq("good_errs", (n_crc - b_crc) + (n_ferr - b_ferr) + (n_to - b_to) + (n_ovr - b_ovr), 0);
    check_eq("good_last", byte_data, 8'hAA);
    accept("good");

    // Bad CRC, then recovery.
    snap();
    send_frame(P1, 8'hF5, 8'hAA);
    check_eq("crc_err", n_crc - b_crc, 1);
    check_eq("crc_norise", n_rise - b_rise, 0);
    check_eq("crc_fvalid", frame_valid, 1'b0);
    send_frame(P1, 8'hF4, 8'hAA);
    check_eq("crc_recover", n_rise - b_rise, 1);
    accept("crc");

    // Junk before header is ignored.
    snap();
    send_byte(8'h00, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_frame(P1, 8'hF4, 8'hAA);
    check_eq("junk_rise", n_rise - b_rise, 1);
    check_eq("junk_bytes", n_byte - b_byte, 15);
    check_eq("junk_errs", (n_crc - b_crc) + (n_ferr - b_ferr) + (n_to - b_to), 0);
    accept("junk");

    // Wrong tail.
    snap();
    send_frame(P1, 8'hF4, 8'hAB);
    check_eq("tail_ferr", n_ferr - b_ferr, 1);
    check_eq("tail_norise", n_rise - b_rise, 0);
    check_eq("tail_nocrc", n_crc - b_crc, 0);

    // Short low glitch on idle line.
    snap();
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (3 * Bps) @(negedge clk);
    check_eq("glitch_bytes", n_byte - b_byte, 0);
    check_eq("glitch_errs", n_ferr - b_ferr, 0);
    check_eq("glitch_busy", busy, 1'b0);

    // Stop bit low.
    snap();
    send_byte(8'h12, 1'b0);
    repeat (Bps) @(negedge clk);
    check_eq("stop_ferr", n_ferr - b_ferr, 1);
    check_eq("stop_bytes", n_byte - b_byte, 0);

    // Line goes quiet mid-payload.
    snap();
    send_byte(8'h55, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(P1[8*i +: 8], 1'b1);
    check_eq("to_busy_pre", busy, 1'b1);
    repeat (25 * Bps) @(negedge clk);
    check_eq("to_pulse", n_to - b_to, 1);
    diff = to_at - last_bv;
    check_eq("to_latency", (diff >= ToBits * Bps) && (diff <= ToBits * Bps + 2), 1'b1);
    check_eq("to_busy", busy, 1'b0);
    check_eq("to_norise", n_rise - b_rise, 0);
    send_frame(P1, 8'hF4, 8'hAA);
    check_eq("to_resend", n_rise - b_rise, 1);
    accept("to");

    // Overrun: second good frame while first is still held.
    snap();
    send_frame(P1, 8'hF4, 8'hAA);
    send_frame(P0, 8'h00, 8'hAA);
    check_eq("ovr_pulse", n_ovr - b_ovr, 1);
    check_eq("ovr_rise", n_rise - b_rise, 1);
    check_eq("ovr_held", frame_data, P1);
    accept("ovr");

    // Reset in the middle of a payload with a frame still held.
    send_frame(P0, 8'h00, 8'hAA);
    check_eq("mrst_pre", frame_valid, 1'b1);
    snap();
    send_byte(8'h55, 1'b1);
    for (int i = 0; i < 3; i++) send_byte(P1[8*i +: 8], 1'b1);
    rxd = 1'b0;
    repeat (3 * Bps) @(negedge clk);
    rst = 1'b1;
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("mrst_fvalid", frame_valid, 1'b0);
    check_eq("mrst_fdata", frame_data, P0);
    check_eq("mrst_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (25 * Bps) @(negedge clk);
    check_eq("mrst_errs", (n_crc - b_crc) + (n_ferr - b_ferr) + (n_to - b_to) + (n_ovr - b_ovr), 0);
    check_eq("mrst_bytes", n_byte - b_byte, 4);
    send_frame(P1, 8'hF4, 8'hAA);
    check_eq("mrst_after", frame_data, P1);
    accept("mrst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
